// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline latches and the hazard controller.
// slave: the controller side; master: the pipeline/datapath side.
interface pipeline_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic [4:0]       ifid_Rs;
   logic [4:0]       ifid_Rt;
   logic             idex_DRen;
   logic [4:0]       idex_Rt;
   logic             exmem_DRen;
   logic             exmem_DWen;
   logic             exmem_pcsrc;
   logic             exmem_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             memwb_flush;
   logic             dmem_ren;
   logic             dmem_wen;
   logic             halt;
   logic [CNT_W-1:0] stall_cnt;

   modport slave (
      input  ihit, dhit, ifid_Rs, ifid_Rt, idex_DRen, idex_Rt,
             exmem_DRen, exmem_DWen, exmem_pcsrc, exmem_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             dmem_ren, dmem_wen, halt, stall_cnt
   );

   modport master (
      output ihit, dhit, ifid_Rs, ifid_Rt, idex_DRen, idex_Rt,
             exmem_DRen, exmem_DWen, exmem_pcsrc, exmem_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             dmem_ren, dmem_wen, halt, stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: latch enables/flushes,
// data-memory request gating, halt tracking and a saturating stall-cycle counter.
module pipeline_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic           CLK,
   input  logic           nRST,
   pipeline_ctrl_if.slave pif
);

   typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

   state_e           state_q, state_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] cnt_q;
   logic             stall_inc;
   logic             memop;
   logic             luse;

   assign memop = pif.exmem_DRen | pif.exmem_DWen;
   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign luse  = pif.idex_DRen && (pif.idex_Rt != 5'd0) &&
                  ((pif.idex_Rt == pif.ifid_Rs) || (pif.idex_Rt == pif.ifid_Rt));

   assign pif.halt      = halt_q;
   assign pif.stall_cnt = cnt_q;

   // Next state and latch controls; hazards resolved in fixed priority order.
   always_comb begin
      state_d         = state_q;
      halt_d          = halt_q;
      stall_inc       = 1'b0;
      pif.pc_en       = 1'b0;
      pif.ifid_en     = 1'b0;
      pif.idex_en     = 1'b0;
      pif.exmem_en    = 1'b0;
      pif.memwb_en    = 1'b0;
      pif.ifid_flush  = 1'b0;
      pif.idex_flush  = 1'b0;
      pif.exmem_flush = 1'b0;
      pif.memwb_flush = 1'b0;
      pif.dmem_ren    = 1'b0;
      pif.dmem_wen    = 1'b0;

      if (!nRST) begin
         // Bubble every latch while reset is held.
         pif.ifid_flush  = 1'b1;
         pif.idex_flush  = 1'b1;
         pif.exmem_flush = 1'b1;
         pif.memwb_flush = 1'b1;
      end else if (state_q != StHalted) begin
         state_d      = StRun;
         pif.pc_en    = 1'b1;
         pif.ifid_en  = 1'b1;
         pif.idex_en  = 1'b1;
         pif.exmem_en = 1'b1;
         pif.memwb_en = 1'b1;
         pif.dmem_ren = pif.exmem_DRen;
         pif.dmem_wen = pif.exmem_DWen;

         if (memop && !pif.dhit) begin
            pif.pc_en       = 1'b0;
            pif.ifid_en     = 1'b0;
            pif.idex_en     = 1'b0;
            pif.exmem_en    = 1'b0;
            pif.memwb_en    = 1'b0;
            pif.memwb_flush = 1'b1;
            state_d         = StMemWait;
            stall_inc       = 1'b1;
         end else if (pif.exmem_halt) begin
            // Let the halt retire into MEM/WB, squash everything younger.
            pif.pc_en       = 1'b0;
            pif.ifid_en     = 1'b0;
            pif.idex_en     = 1'b0;
            pif.exmem_en    = 1'b0;
            pif.idex_flush  = 1'b1;
            pif.exmem_flush = 1'b1;
            state_d         = StHalted;
            halt_d          = 1'b1;
         end else if (pif.exmem_pcsrc) begin
            pif.ifid_flush  = 1'b1;
            pif.idex_flush  = 1'b1;
            pif.exmem_flush = 1'b1;
         end else if (luse) begin
            // Holding IF/ID here also covers a concurrent fetch miss.
            pif.pc_en      = 1'b0;
            pif.ifid_en    = 1'b0;
            pif.idex_flush = 1'b1;
            stall_inc      = 1'b1;
         end else if (!pif.ihit) begin
            pif.pc_en      = 1'b0;
            pif.ifid_flush = 1'b1;
         end
      end
   end

   // State, halt flag and saturating stall counter.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= StRun;
         halt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         if (stall_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage MIPS pipeline. Generates per-latch enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB, gates data-memory requests from the MEM stage, resolves load-use, memory-wait, fetch-wait, taken-control-flow and halt conditions by fixed priority, and keeps a saturating stall-cycle counter. One instance per core, sitting beside the pipeline latches and driving their enable and flush inputs.

## Interface

- `CNT_W`, default 16: stall counter width.

- `CLK`  in  1  core clock, rising edge.
- `nRST`  in  1  synchronous reset, active low.
- `ihit`  in  1  instruction fetch complete this cycle.
- `dhit`  in  1  data access complete this cycle.
- `ifid_Rs`  in  5  source register Rs of the instruction in ID.
- `ifid_Rt`  in  5  source register Rt of the instruction in ID.
- `idex_DRen`  in  1  instruction in EX is a load.
- `idex_Rt`  in  5  destination register Rt of the instruction in EX.
- `exmem_DRen`  in  1  instruction in MEM reads data memory.
- `exmem_DWen`  in  1  instruction in MEM writes data memory.
- `exmem_pcsrc`  in  1  taken branch, jump or jr resolved in MEM.
- `exmem_halt`  in  1  halt instruction in MEM.
- `pc_en`  out  1  PC register load.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  latch enable.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  load a bubble (synchronous, overrides enable).
- `dmem_ren`, `dmem_wen`  out  1 each  data-memory request.
- `halt`  out  1  core halted, registered.
- `stall_cnt`  out  CNT_W  saturating stall-cycle count.

## Operation

- States: RUN, MEMWAIT, HALTED. State, `halt` and `stall_cnt` are registered; all other outputs are combinational from state and inputs.
- memop = `exmem_DRen | exmem_DWen`. luse = `idex_DRen` & `idex_Rt` != 0 & (`idex_Rt` == `ifid_Rs` | `idex_Rt` == `ifid_Rt`).
- `dmem_ren` = `exmem_DRen`, `dmem_wen` = `exmem_DWen` in RUN/MEMWAIT; both 0 in HALTED.
- Defaults (RUN/MEMWAIT): all enables 1, all flushes 0. Conditions are applied in priority order; the first match wins.
  1. Memory wait (memop & !`dhit`): all enables 0; `memwb_flush`=1. Next state MEMWAIT.
  2. Halt (`exmem_halt`): `memwb_en`=1, all other enables 0; `idex_flush`=`exmem_flush`=1. Next state HALTED; `halt` is set to 1.
  3. Taken control flow (`exmem_pcsrc`): `pc_en`=1; `ifid_flush`=`idex_flush`=`exmem_flush`=1.
  4. Load-use (luse): `pc_en`=`ifid_en`=0; `idex_flush`=1.
  5. Fetch wait (!`ihit`): `pc_en`=0; `ifid_flush`=1.
- If condition 1 does not match, the next state is RUN. This includes MEMWAIT with `dhit`=1: the stalled instruction advances that cycle, and conditions 2-5 are evaluated as usual.
- HALTED: all enables 0, all flushes 0, `halt`=1. The block leaves HALTED only on reset.
- `stall_cnt` increments by 1 in each cycle where condition 1 or condition 4 is the winning condition. It saturates at all-ones and never wraps. It holds in HALTED.
- While `nRST`=0 (sampled): all enables 0, all flushes 1, `dmem_ren`=`dmem_wen`=0. On the clock edge: state becomes RUN, `halt` becomes 0, `stall_cnt` becomes 0. A reset during MEMWAIT or HALTED behaves identically.

## Timing

- Combinational outputs are valid in the same cycle as their inputs. Flush and enable take effect at the next rising edge of `CLK`.
- A memory stall adds exactly N cycles, where `dhit` arrives N cycles after the request first asserts. With `dhit` in the first cycle, there is no stall.
- A taken branch costs 3 bubbles (IF/ID, ID/EX, EX/MEM squashed).
- Load-use costs 1 bubble when the memory is not also stalling.
- `halt` rises one cycle after `exmem_halt` is first seen in RUN with no memory wait.
- Simultaneous luse and !`ihit`: the load-use rule wins. The PC holds and IF/ID holds; it is not flushed.

## Test plan

- Reset, then one idle cycle: hold `nRST`=0 for 2 cycles, then release with `ihit`=1 and no hazards -> after release, state RUN, all enables 1, all flushes 0, `halt`=0, `stall_cnt`=0.
- Load-use: `idex_DRen`=1, `idex_Rt`=5, `ifid_Rs`=5, `ihit`=1 -> `pc_en`=0, `ifid_en`=0, `idex_flush`=1, and `stall_cnt` goes 0->1. Repeat with `idex_Rt`=0 -> no stall.
- Memory wait: `exmem_DRen`=1 with `dhit` low for 3 cycles, then high -> 3 cycles with all enables 0 and `memwb_flush`=1, `dmem_ren`=1 throughout; on the `dhit` cycle all enables are 1; `stall_cnt`=3.
- Taken branch together with `ihit`=0: `exmem_pcsrc`=1 -> `pc_en`=1, `ifid_flush`=`idex_flush`=`exmem_flush`=1.
- Halt behind a pending store: `exmem_DWen`=1 and `exmem_halt`=1 with `dhit`=0 for 1 cycle, then 1 -> first cycle is a memory stall; second cycle has `memwb_en`=1 only; next cycle `halt`=1. The block stays HALTED for 10 cycles regardless of inputs, and `nRST` low returns `halt` to 0.
- Counter saturation with `CNT_W`=4: force 20 consecutive load-use cycles -> `stall_cnt` stops at 15 and does not wrap.
